// File: rtl/rvfi_commit_tracker.sv
// RVFI retirement producer: shadows per-ROB-entry architectural side information
// and emits one registered RVFI packet per retiring instruction per commit lane.
module rvfi_commit_tracker #(
  parameter int unsigned ROB_DEPTH = 16,
  parameter int unsigned ROB_IDX_W = 4,
  parameter int unsigned COMMIT_W  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          dispatch_valid,
  input  logic [ROB_IDX_W-1:0]          dispatch_rob_idx,
  input  logic [31:0]                   dispatch_pc,
  input  logic [31:0]                   dispatch_inst,
  input  logic [4:0]                    dispatch_rs1_addr,
  input  logic [4:0]                    dispatch_rs2_addr,
  input  logic [4:0]                    dispatch_rd_addr,
  input  logic                          rs_read_valid,
  input  logic [ROB_IDX_W-1:0]          rs_read_rob_idx,
  input  logic [31:0]                   rs1_rdata,
  input  logic [31:0]                   rs2_rdata,
  input  logic                          wb_valid,
  input  logic [ROB_IDX_W-1:0]          wb_rob_idx,
  input  logic [31:0]                   wb_rd_wdata,
  input  logic                          wb_pc_wdata_valid,
  input  logic [31:0]                   wb_pc_wdata,
  input  logic                          mem_valid,
  input  logic [ROB_IDX_W-1:0]          mem_rob_idx,
  input  logic [31:0]                   mem_addr,
  input  logic [3:0]                    mem_rmask,
  input  logic [3:0]                    mem_wmask,
  input  logic [31:0]                   mem_rdata,
  input  logic [31:0]                   mem_wdata,
  input  logic [COMMIT_W-1:0]           commit_valid,
  input  logic [COMMIT_W*ROB_IDX_W-1:0] commit_rob_idx,
  input  logic                          flush,
  output logic [COMMIT_W-1:0]           rvfi_valid,
  output logic [COMMIT_W*64-1:0]        rvfi_order,
  output logic [COMMIT_W*32-1:0]        rvfi_inst,
  output logic [COMMIT_W*32-1:0]        rvfi_pc_rdata,
  output logic [COMMIT_W*32-1:0]        rvfi_pc_wdata,
  output logic [COMMIT_W*32-1:0]        rvfi_rs1_rdata,
  output logic [COMMIT_W*32-1:0]        rvfi_rs2_rdata,
  output logic [COMMIT_W*32-1:0]        rvfi_rd_wdata,
  output logic [COMMIT_W*32-1:0]        rvfi_mem_addr,
  output logic [COMMIT_W*32-1:0]        rvfi_mem_rdata,
  output logic [COMMIT_W*32-1:0]        rvfi_mem_wdata,
  output logic [COMMIT_W*5-1:0]         rvfi_rs1_addr,
  output logic [COMMIT_W*5-1:0]         rvfi_rs2_addr,
  output logic [COMMIT_W*5-1:0]         rvfi_rd_addr,
  output logic [COMMIT_W*4-1:0]         rvfi_mem_rmask,
  output logic [COMMIT_W*4-1:0]         rvfi_mem_wmask,
  output logic                          error
);

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } pkt_t;

  logic [31:0] pc_q        [ROB_DEPTH];
  logic [31:0] inst_q      [ROB_DEPTH];
  logic [31:0] pc_wdata_q  [ROB_DEPTH];
  logic [4:0]  rs1_addr_q  [ROB_DEPTH];
  logic [4:0]  rs2_addr_q  [ROB_DEPTH];
  logic [4:0]  rd_addr_q   [ROB_DEPTH];
  logic [31:0] rs1_data_q  [ROB_DEPTH];
  logic [31:0] rs2_data_q  [ROB_DEPTH];
  logic [31:0] rd_data_q   [ROB_DEPTH];
  logic [31:0] mem_addr_q  [ROB_DEPTH];
  logic [3:0]  mem_rmask_q [ROB_DEPTH];
  logic [3:0]  mem_wmask_q [ROB_DEPTH];
  logic [31:0] mem_rdata_q [ROB_DEPTH];
  logic [31:0] mem_wdata_q [ROB_DEPTH];

  logic [ROB_DEPTH-1:0] dispatched_q, dispatched_d;
  logic [ROB_DEPTH-1:0] wb_done_q, wb_done_d;
  logic [63:0]          order_q, order_d;
  logic [COMMIT_W-1:0]  valid_q;
  logic                 error_q, err_d;
  pkt_t                 pkt_q [COMMIT_W];
  pkt_t                 pkt_d [COMMIT_W];
  logic [ROB_IDX_W-1:0] lane_idx [COMMIT_W];
  logic [ROB_IDX_W-1:0] sel;
  logic [63:0]          run;

  logic disp_en, rs_en, wb_en, mem_en;

  // Flush squashes every same-cycle dispatch and capture.
  assign disp_en = dispatch_valid & ~flush;
  assign rs_en   = rs_read_valid & ~flush;
  assign wb_en   = wb_valid & ~flush;
  assign mem_en  = mem_valid & ~flush;

  always_ff @(posedge clk) begin
    if (disp_en) begin
      pc_q[dispatch_rob_idx]        <= dispatch_pc;
      inst_q[dispatch_rob_idx]      <= dispatch_inst;
      rs1_addr_q[dispatch_rob_idx]  <= dispatch_rs1_addr;
      rs2_addr_q[dispatch_rob_idx]  <= dispatch_rs2_addr;
      rd_addr_q[dispatch_rob_idx]   <= dispatch_rd_addr;
      rs1_data_q[dispatch_rob_idx]  <= '0;
      rs2_data_q[dispatch_rob_idx]  <= '0;
      rd_data_q[dispatch_rob_idx]   <= '0;
      mem_addr_q[dispatch_rob_idx]  <= '0;
      mem_rmask_q[dispatch_rob_idx] <= '0;
      mem_wmask_q[dispatch_rob_idx] <= '0;
      mem_rdata_q[dispatch_rob_idx] <= '0;
      mem_wdata_q[dispatch_rob_idx] <= '0;
      pc_wdata_q[dispatch_rob_idx]  <= (dispatch_inst[1:0] == 2'b11) ?
                                       dispatch_pc + 32'd4 : dispatch_pc + 32'd2;
    end
    // Captures follow dispatch so a same-cycle capture to a fresh entry survives.
    if (rs_en) begin
      rs1_data_q[rs_read_rob_idx] <= rs1_rdata;
      rs2_data_q[rs_read_rob_idx] <= rs2_rdata;
    end
    if (wb_en) begin
      rd_data_q[wb_rob_idx] <= wb_rd_wdata;
      if (wb_pc_wdata_valid) pc_wdata_q[wb_rob_idx] <= wb_pc_wdata;
    end
    if (mem_en) begin
      mem_addr_q[mem_rob_idx]  <= mem_addr;
      mem_rmask_q[mem_rob_idx] <= mem_rmask;
      mem_wmask_q[mem_rob_idx] <= mem_wmask;
      mem_rdata_q[mem_rob_idx] <= mem_rdata;
      mem_wdata_q[mem_rob_idx] <= mem_wdata;
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < COMMIT_W; l++)
      lane_idx[l] = commit_rob_idx[l*ROB_IDX_W +: ROB_IDX_W];
  end

  // Priority, lowest first: writeback set, commit free, dispatch re-init, flush.
  always_comb begin
    dispatched_d = dispatched_q;
    wb_done_d    = wb_done_q;
    if (wb_en) wb_done_d[wb_rob_idx] = 1'b1;
    for (int unsigned l = 0; l < COMMIT_W; l++) begin
      if (commit_valid[l]) begin
        dispatched_d[lane_idx[l]] = 1'b0;
        wb_done_d[lane_idx[l]]    = 1'b0;
      end
    end
    if (disp_en) begin
      dispatched_d[dispatch_rob_idx] = 1'b1;
      wb_done_d[dispatch_rob_idx]    = 1'b0;
    end
    if (flush) begin
      dispatched_d = '0;
      wb_done_d    = '0;
    end
  end

  always_comb begin
    err_d = 1'b0;
    run   = '0;
    sel   = '0;
    for (int unsigned l = 0; l < COMMIT_W; l++) begin
      pkt_d[l] = '0;
      sel      = lane_idx[l];
      if (commit_valid[l]) begin
        pkt_d[l].order     = order_q + run;
        pkt_d[l].inst      = inst_q[sel];
        pkt_d[l].pc_rdata  = pc_q[sel];
        pkt_d[l].pc_wdata  = pc_wdata_q[sel];
        pkt_d[l].rs1_addr  = rs1_addr_q[sel];
        pkt_d[l].rs2_addr  = rs2_addr_q[sel];
        pkt_d[l].rd_addr   = rd_addr_q[sel];
        pkt_d[l].rs1_rdata = rs1_data_q[sel];
        pkt_d[l].rs2_rdata = rs2_data_q[sel];
        pkt_d[l].rd_wdata  = rd_data_q[sel];
        pkt_d[l].mem_addr  = mem_addr_q[sel];
        pkt_d[l].mem_rmask = mem_rmask_q[sel];
        pkt_d[l].mem_wmask = mem_wmask_q[sel];
        pkt_d[l].mem_rdata = mem_rdata_q[sel];
        pkt_d[l].mem_wdata = mem_wdata_q[sel];
        if (rs_en && rs_read_rob_idx == sel) begin
          pkt_d[l].rs1_rdata = rs1_rdata;
          pkt_d[l].rs2_rdata = rs2_rdata;
        end
        if (wb_en && wb_rob_idx == sel) begin
          pkt_d[l].rd_wdata = wb_rd_wdata;
          if (wb_pc_wdata_valid) pkt_d[l].pc_wdata = wb_pc_wdata;
        end
        if (mem_en && mem_rob_idx == sel) begin
          pkt_d[l].mem_addr  = mem_addr;
          pkt_d[l].mem_rmask = mem_rmask;
          pkt_d[l].mem_wmask = mem_wmask;
          pkt_d[l].mem_rdata = mem_rdata;
          pkt_d[l].mem_wdata = mem_wdata;
        end
        if (pkt_d[l].rs1_addr == 5'd0) pkt_d[l].rs1_rdata = '0;
        if (pkt_d[l].rs2_addr == 5'd0) pkt_d[l].rs2_rdata = '0;
        if (pkt_d[l].rd_addr == 5'd0)  pkt_d[l].rd_wdata  = '0;
        if (!dispatched_q[sel] || !(wb_done_q[sel] || (wb_en && wb_rob_idx == sel)))
          err_d = 1'b1;
      end
      run = run + {63'd0, commit_valid[l]};
    end
    for (int unsigned l = 1; l < COMMIT_W; l++)
      if (commit_valid[l] && !commit_valid[l-1]) err_d = 1'b1;
    order_d = order_q + run;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dispatched_q <= '0;
      wb_done_q    <= '0;
      order_q      <= '0;
      valid_q      <= '0;
      error_q      <= 1'b0;
      for (int unsigned l = 0; l < COMMIT_W; l++) pkt_q[l] <= '0;
    end else begin
      dispatched_q <= dispatched_d;
      wb_done_q    <= wb_done_d;
      order_q      <= order_d;
      valid_q      <= commit_valid;
      error_q      <= error_q | err_d;
      for (int unsigned l = 0; l < COMMIT_W; l++) pkt_q[l] <= pkt_d[l];
    end
  end

  assign rvfi_valid = valid_q;
  assign error      = error_q;

  for (genvar g = 0; g < COMMIT_W; g++) begin : g_lane
    assign rvfi_order[g*64 +: 64]     = pkt_q[g].order;
    assign rvfi_inst[g*32 +: 32]      = pkt_q[g].inst;
    assign rvfi_pc_rdata[g*32 +: 32]  = pkt_q[g].pc_rdata;
    assign rvfi_pc_wdata[g*32 +: 32]  = pkt_q[g].pc_wdata;
    assign rvfi_rs1_rdata[g*32 +: 32] = pkt_q[g].rs1_rdata;
    assign rvfi_rs2_rdata[g*32 +: 32] = pkt_q[g].rs2_rdata;
    assign rvfi_rd_wdata[g*32 +: 32]  = pkt_q[g].rd_wdata;
    assign rvfi_mem_addr[g*32 +: 32]  = pkt_q[g].mem_addr;
    assign rvfi_mem_rdata[g*32 +: 32] = pkt_q[g].mem_rdata;
    assign rvfi_mem_wdata[g*32 +: 32] = pkt_q[g].mem_wdata;
    assign rvfi_rs1_addr[g*5 +: 5]    = pkt_q[g].rs1_addr;
    assign rvfi_rs2_addr[g*5 +: 5]    = pkt_q[g].rs2_addr;
    assign rvfi_rd_addr[g*5 +: 5]     = pkt_q[g].rd_addr;
    assign rvfi_mem_rmask[g*4 +: 4]   = pkt_q[g].mem_rmask;
    assign rvfi_mem_wmask[g*4 +: 4]   = pkt_q[g].mem_wmask;
  end

endmodule

// File: tb/tb_rvfi_commit_tracker.sv
// Directed self-checking bench for rvfi_commit_tracker (ROB_DEPTH=16, COMMIT_W=2).
module tb_rvfi_commit_tracker;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dispatch_valid;
  logic [3:0]  dispatch_rob_idx;
  logic [31:0] dispatch_pc, dispatch_inst;
  logic [4:0]  dispatch_rs1_addr, dispatch_rs2_addr, dispatch_rd_addr;
  logic        rs_read_valid;
  logic [3:0]  rs_read_rob_idx;
  logic [31:0] rs1_rdata, rs2_rdata;
  logic        wb_valid;
  logic [3:0]  wb_rob_idx;
  logic [31:0] wb_rd_wdata;
  logic        wb_pc_wdata_valid;
  logic [31:0] wb_pc_wdata;
  logic        mem_valid;
  logic [3:0]  mem_rob_idx;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask, mem_wmask;
  logic [31:0] mem_rdata, mem_wdata;
  logic [1:0]  commit_valid;
  logic [7:0]  commit_rob_idx;
  logic        flush;
  logic [1:0]  rvfi_valid;
  logic [127:0] rvfi_order;
  logic [63:0] rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata;
  logic [63:0] rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [9:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [7:0]  rvfi_mem_rmask, rvfi_mem_wmask;
  logic        error;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rvfi_commit_tracker #(.ROB_DEPTH(16), .ROB_IDX_W(4), .COMMIT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .dispatch_valid(dispatch_valid), .dispatch_rob_idx(dispatch_rob_idx),
    .dispatch_pc(dispatch_pc), .dispatch_inst(dispatch_inst),
    .dispatch_rs1_addr(dispatch_rs1_addr), .dispatch_rs2_addr(dispatch_rs2_addr),
    .dispatch_rd_addr(dispatch_rd_addr),
    .rs_read_valid(rs_read_valid), .rs_read_rob_idx(rs_read_rob_idx),
    .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
    .wb_valid(wb_valid), .wb_rob_idx(wb_rob_idx), .wb_rd_wdata(wb_rd_wdata),
    .wb_pc_wdata_valid(wb_pc_wdata_valid), .wb_pc_wdata(wb_pc_wdata),
    .mem_valid(mem_valid), .mem_rob_idx(mem_rob_idx), .mem_addr(mem_addr),
    .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .commit_valid(commit_valid), .commit_rob_idx(commit_rob_idx), .flush(flush),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_inst(rvfi_inst),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask), .error(error)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    dispatch_valid = 1'b0; dispatch_rob_idx = '0; dispatch_pc = '0; dispatch_inst = '0;
    dispatch_rs1_addr = '0; dispatch_rs2_addr = '0; dispatch_rd_addr = '0;
    rs_read_valid = 1'b0; rs_read_rob_idx = '0; rs1_rdata = '0; rs2_rdata = '0;
    wb_valid = 1'b0; wb_rob_idx = '0; wb_rd_wdata = '0;
    wb_pc_wdata_valid = 1'b0; wb_pc_wdata = '0;
    mem_valid = 1'b0; mem_rob_idx = '0; mem_addr = '0; mem_rmask = '0; mem_wmask = '0;
    mem_rdata = '0; mem_wdata = '0;
    commit_valid = '0; commit_rob_idx = '0; flush = 1'b0;
  endtask

  task automatic set_disp(input logic [3:0] idx, input logic [31:0] pc, input logic [31:0] inst,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    dispatch_valid = 1'b1; dispatch_rob_idx = idx; dispatch_pc = pc; dispatch_inst = inst;
    dispatch_rs1_addr = r1; dispatch_rs2_addr = r2; dispatch_rd_addr = rd;
  endtask

  task automatic set_wb(input logic [3:0] idx, input logic [31:0] d);
    wb_valid = 1'b1; wb_rob_idx = idx; wb_rd_wdata = d;
  endtask

  task automatic set_commit(input logic [1:0] v, input logic [3:0] i0, input logic [3:0] i1);
    commit_valid = v; commit_rob_idx = {i1, i0};
  endtask

  task automatic do_reset;
    idle();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    idle();
    #12;
    checks++; if (rvfi_valid !== 2'b00) begin failures++; $display("FAIL reset_valid got=%h exp=0", rvfi_valid); end
    checks++; if (rvfi_order !== 128'd0) begin failures++; $display("FAIL reset_order got=%h exp=0", rvfi_order); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    set_disp(4'd3, 32'h1000, 32'h00500093, 5'd0, 5'd0, 5'd1); tick(); idle();
    rs_read_valid = 1'b1; rs_read_rob_idx = 4'd3; rs1_rdata = 32'h77; rs2_rdata = 32'h88; tick(); idle();
    set_wb(4'd3, 32'd5); tick(); idle();
    set_commit(2'b01, 4'd3, 4'd0); tick(); idle();
    checks++; if (rvfi_valid !== 2'b01) begin failures++; $display("FAIL basic_valid got=%b exp=01", rvfi_valid); end
    checks++; if (rvfi_order[63:0] !== 64'd0) begin failures++; $display("FAIL basic_order got=%0d exp=0", rvfi_order[63:0]); end
    checks++; if (rvfi_rd_addr[4:0] !== 5'd1) begin failures++; $display("FAIL basic_rd_addr got=%0d exp=1", rvfi_rd_addr[4:0]); end
    checks++; if (rvfi_rd_wdata[31:0] !== 32'd5) begin failures++; $display("FAIL basic_rd_wdata got=%h exp=5", rvfi_rd_wdata[31:0]); end
    checks++; if (rvfi_pc_wdata[31:0] !== 32'h1004) begin failures++; $display("FAIL basic_pc_wdata got=%h exp=1004", rvfi_pc_wdata[31:0]); end
    checks++; if (rvfi_pc_rdata[31:0] !== 32'h1000) begin failures++; $display("FAIL basic_pc_rdata got=%h exp=1000", rvfi_pc_rdata[31:0]); end
    checks++; if (rvfi_inst[31:0] !== 32'h00500093) begin failures++; $display("FAIL basic_inst got=%h exp=00500093", rvfi_inst[31:0]); end
    checks++; if (rvfi_rs1_rdata[31:0] !== 32'd0) begin failures++; $display("FAIL basic_rs1_x0 got=%h exp=0", rvfi_rs1_rdata[31:0]); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL basic_error got=%b exp=0", error); end
    tick();
    checks++; if (rvfi_valid !== 2'b00) begin failures++; $display("FAIL basic_valid_drop got=%b exp=00", rvfi_valid); end
  endtask

  task automatic test_pc_wdata;
    set_disp(4'd6, 32'h2002, 32'h00004505, 5'd0, 5'd0, 5'd10); tick(); idle();
    set_disp(4'd7, 32'h3000, 32'h00208463, 5'd1, 5'd2, 5'd0); tick(); idle();
    set_wb(4'd6, 32'h11); tick(); idle();
    set_wb(4'd7, 32'h0); wb_pc_wdata_valid = 1'b1; wb_pc_wdata = 32'h3100; tick(); idle();
    set_commit(2'b11, 4'd6, 4'd7); tick(); idle();
    checks++; if (rvfi_valid !== 2'b11) begin failures++; $display("FAIL pcw_valid got=%b exp=11", rvfi_valid); end
    checks++; if (rvfi_pc_wdata[31:0] !== 32'h2004) begin failures++; $display("FAIL pcw_compressed got=%h exp=2004", rvfi_pc_wdata[31:0]); end
    checks++; if (rvfi_pc_wdata[63:32] !== 32'h3100) begin failures++; $display("FAIL pcw_branch got=%h exp=3100", rvfi_pc_wdata[63:32]); end
    checks++; if (rvfi_order[63:0] !== 64'd1) begin failures++; $display("FAIL pcw_order0 got=%0d exp=1", rvfi_order[63:0]); end
    checks++; if (rvfi_order[127:64] !== 64'd2) begin failures++; $display("FAIL pcw_order1 got=%0d exp=2", rvfi_order[127:64]); end
    checks++; if (rvfi_rd_wdata[31:0] !== 32'h11) begin failures++; $display("FAIL pcw_rd_wdata got=%h exp=11", rvfi_rd_wdata[31:0]); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL pcw_error got=%b exp=0", error); end
  endtask

  task automatic test_multilane;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_disp(4'(i), 32'h100 + 32'(4*i), 32'h00000013, 5'd0, 5'd0, 5'(i+1)); tick(); idle();
    end
    for (int i = 0; i < 5; i++) begin
      set_wb(4'(i), 32'hA0 + 32'(i)); tick(); idle();
    end
    set_commit(2'b11, 4'd0, 4'd1); tick(); idle();
    checks++; if (rvfi_order[63:0] !== 64'd0 || rvfi_order[127:64] !== 64'd1) begin failures++; $display("FAIL ml_orders_a got=%0d,%0d exp=0,1", rvfi_order[63:0], rvfi_order[127:64]); end
    set_commit(2'b01, 4'd2, 4'd0); tick(); idle();
    checks++; if (rvfi_valid !== 2'b01 || rvfi_order[63:0] !== 64'd2) begin failures++; $display("FAIL ml_orders_b got=%b/%0d exp=01/2", rvfi_valid, rvfi_order[63:0]); end
    set_commit(2'b11, 4'd3, 4'd4); tick(); idle();
    checks++; if (rvfi_order[63:0] !== 64'd3 || rvfi_order[127:64] !== 64'd4) begin failures++; $display("FAIL ml_orders_c got=%0d,%0d exp=3,4", rvfi_order[63:0], rvfi_order[127:64]); end
    checks++; if (rvfi_rd_wdata[63:32] !== 32'hA4) begin failures++; $display("FAIL ml_lane1_rd got=%h exp=a4", rvfi_rd_wdata[63:32]); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL ml_error_clean got=%b exp=0", error); end
    set_disp(4'd5, 32'h200, 32'h00000013, 5'd0, 5'd0, 5'd6); tick(); idle();
    set_wb(4'd5, 32'h55); tick(); idle();
    set_commit(2'b10, 4'd0, 4'd5); tick(); idle();
    checks++; if (rvfi_valid !== 2'b10) begin failures++; $display("FAIL ml_gap_valid got=%b exp=10", rvfi_valid); end
    checks++; if (rvfi_order[127:64] !== 64'd5) begin failures++; $display("FAIL ml_gap_order got=%0d exp=5", rvfi_order[127:64]); end
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL ml_gap_error got=%b exp=1", error); end
  endtask

  task automatic test_bypass;
    do_reset();
    set_disp(4'd5, 32'h500, 32'h00000013, 5'd0, 5'd0, 5'd3); tick(); idle();
    set_commit(2'b01, 4'd5, 4'd0); set_wb(4'd5, 32'hDEADBEEF); tick(); idle();
    checks++; if (rvfi_rd_wdata[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL byp_rd_wdata got=%h exp=deadbeef", rvfi_rd_wdata[31:0]); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL byp_error got=%b exp=0", error); end
    set_commit(2'b01, 4'd9, 4'd0); tick(); idle();
    checks++; if (rvfi_valid !== 2'b01) begin failures++; $display("FAIL undisp_valid got=%b exp=01", rvfi_valid); end
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL undisp_error got=%b exp=1", error); end
    tick(); tick();
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL error_sticky got=%b exp=1", error); end
  endtask

  task automatic test_mem;
    do_reset();
    set_disp(4'd8, 32'h400, 32'h00312023, 5'd2, 5'd3, 5'd0); tick(); idle();
    rs_read_valid = 1'b1; rs_read_rob_idx = 4'd8; rs1_rdata = 32'h80; rs2_rdata = 32'h12345678;
    set_disp(4'd9, 32'h404, 32'h00012003, 5'd2, 5'd0, 5'd0); tick(); idle();
    mem_valid = 1'b1; mem_rob_idx = 4'd8; mem_addr = 32'h80; mem_wmask = 4'hF; mem_wdata = 32'h12345678;
    set_wb(4'd9, 32'hAB); tick(); idle();
    set_wb(4'd8, 32'h999); tick(); idle();
    mem_valid = 1'b1; mem_rob_idx = 4'd9; mem_addr = 32'h84; mem_rmask = 4'hF; mem_rdata = 32'hCAFEF00D;
    set_commit(2'b11, 4'd8, 4'd9); tick(); idle();
    checks++; if (rvfi_mem_addr[31:0] !== 32'h80) begin failures++; $display("FAIL st_addr got=%h exp=80", rvfi_mem_addr[31:0]); end
    checks++; if (rvfi_mem_wmask[3:0] !== 4'hF || rvfi_mem_rmask[3:0] !== 4'h0) begin failures++; $display("FAIL st_masks got=w%h/r%h exp=wf/r0", rvfi_mem_wmask[3:0], rvfi_mem_rmask[3:0]); end
    checks++; if (rvfi_mem_wdata[31:0] !== 32'h12345678) begin failures++; $display("FAIL st_wdata got=%h exp=12345678", rvfi_mem_wdata[31:0]); end
    checks++; if (rvfi_rs2_rdata[31:0] !== 32'h12345678) begin failures++; $display("FAIL st_rs2 got=%h exp=12345678", rvfi_rs2_rdata[31:0]); end
    checks++; if (rvfi_rd_wdata[31:0] !== 32'd0) begin failures++; $display("FAIL st_rd_x0 got=%h exp=0", rvfi_rd_wdata[31:0]); end
    checks++; if (rvfi_rd_wdata[63:32] !== 32'd0) begin failures++; $display("FAIL ld_rd_x0 got=%h exp=0", rvfi_rd_wdata[63:32]); end
    checks++; if (rvfi_mem_rdata[63:32] !== 32'hCAFEF00D || rvfi_mem_addr[63:32] !== 32'h84) begin failures++; $display("FAIL ld_mem_bypass got=%h@%h exp=cafef00d@84", rvfi_mem_rdata[63:32], rvfi_mem_addr[63:32]); end
    checks++; if (rvfi_mem_rmask[7:4] !== 4'hF) begin failures++; $display("FAIL ld_rmask got=%h exp=f", rvfi_mem_rmask[7:4]); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL mem_error got=%b exp=0", error); end
  endtask

  task automatic test_flush;
    do_reset();
    set_disp(4'd2, 32'h200, 32'h00000013, 5'd0, 5'd0, 5'd4); tick(); idle();
    set_wb(4'd2, 32'h22); tick(); idle();
    set_commit(2'b01, 4'd2, 4'd0); flush = 1'b1;
    set_disp(4'd4, 32'h400, 32'h00000013, 5'd0, 5'd0, 5'd5); tick(); idle();
    checks++; if (rvfi_valid !== 2'b01 || rvfi_pc_rdata[31:0] !== 32'h200) begin failures++; $display("FAIL fl_packet got=%b/%h exp=01/200", rvfi_valid, rvfi_pc_rdata[31:0]); end
    checks++; if (rvfi_rd_wdata[31:0] !== 32'h22) begin failures++; $display("FAIL fl_rd_wdata got=%h exp=22", rvfi_rd_wdata[31:0]); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL fl_error_clean got=%b exp=0", error); end
    set_wb(4'd4, 32'h44); tick(); idle();
    set_commit(2'b01, 4'd4, 4'd0); tick(); idle();
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL fl_dropped_dispatch got=%b exp=1", error); end
    checks++; if (rvfi_order[63:0] !== 64'd1) begin failures++; $display("FAIL fl_order got=%0d exp=1", rvfi_order[63:0]); end
  endtask

  task automatic test_async_reset;
    do_reset();
    set_disp(4'd1, 32'h700, 32'h00000013, 5'd0, 5'd0, 5'd2); tick(); idle();
    set_wb(4'd1, 32'h7); tick(); idle();
    set_commit(2'b01, 4'd1, 4'd0); tick(); idle();
    set_commit(2'b01, 4'd12, 4'd0); tick(); idle();
    checks++; if (rvfi_order[63:0] !== 64'd1 || error !== 1'b1) begin failures++; $display("FAIL ar_pre got=%0d/%b exp=1/1", rvfi_order[63:0], error); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rvfi_valid !== 2'b00 || rvfi_order !== 128'd0) begin failures++; $display("FAIL ar_async_out got=%b/%0d exp=00/0", rvfi_valid, rvfi_order[63:0]); end
    checks++; if (error !== 1'b0 || rvfi_pc_rdata !== 64'd0) begin failures++; $display("FAIL ar_async_err got=%b/%h exp=0/0", error, rvfi_pc_rdata); end
    rst_n = 1'b1;
    set_disp(4'd1, 32'h800, 32'h00000013, 5'd0, 5'd0, 5'd2); tick(); idle();
    set_wb(4'd1, 32'h8); tick(); idle();
    set_commit(2'b01, 4'd1, 4'd0); tick(); idle();
    checks++; if (rvfi_order[63:0] !== 64'd0 || rvfi_pc_rdata[31:0] !== 32'h800) begin failures++; $display("FAIL ar_restart got=%0d/%h exp=0/800", rvfi_order[63:0], rvfi_pc_rdata[31:0]); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL ar_error got=%b exp=0", error); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pc_wdata();
    test_multilane();
    test_bypass();
    test_mem();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
